dequantizer: RTL and testbench

//  Inverse of the output quantizer: converts an int8 activation stream back to
//  int32 fixed-point (x - zp) * M >>> n, using a per-channel scale table.

---
 rtl/dequantizer.sv | 201 ++++++++++++++++++++
 tb/tb_dequantizer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantizer.sv
// ---------------------------------------------------------------------------
// dequantizer
//
// Converts a signed int8 activation stream back to int32 fixed point:
//   out = sat32( ((in - zp) * M[ch]) >>> n[ch] )
// where {M, n} comes from a per-channel scale table and the channel index
// cycles 0..NUM_CH-1 with every accepted beat. Three-stage pipeline with a
// single global advance enable, so backpressure from the output freezes all
// stages together.
//
// Build option:
//   DEQUANT_ROUND_EN  defined   -> S3 adds 2^(n-1) before the shift
//                                  (round half toward +inf)
//                     undefined -> plain arithmetic shift (floor)
//   Latency and handshake are identical in both builds.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data_i       signed int8 activation
//   in_valid_i      in_data_i valid
//   in_ready_o      block accepts in_data_i this cycle
//   zp_i            signed int8 zero point (static while streaming)
//   ch_clear_i      pulse: channel counter back to 0
//   cfg_we_i        scale-table write strobe
//   cfg_addr_i      table entry to write
//   cfg_m_i         unsigned 32-bit multiplier for the entry
//   cfg_n_i         right-shift amount for the entry
//   out_data_o      signed int32 result
//   out_ch_o        channel index of out_data_o
//   out_valid_o     out_data_o / out_ch_o valid
//   out_ready_i     downstream accepts
// ---------------------------------------------------------------------------
module dequantizer #(
  parameter  int NUM_CH = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       zp_i,
  input  logic             ch_clear_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_addr_i,
  input  logic [31:0]      cfg_m_i,
  input  logic [4:0]       cfg_n_i,
  output logic [31:0]      out_data_o,
  output logic [CH_W-1:0]  out_ch_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  // Scale table (intentionally not reset; software programs it before use)
  logic [31:0]      m_tab_q [NUM_CH];
  logic [4:0]       n_tab_q [NUM_CH];

  // Channel counter
  logic [CH_W-1:0]  ch_cnt_q;
  logic [CH_W-1:0]  ch_cnt_d;

  // Stage 1: offset-removed activation plus looked-up scale
  logic             s1_valid_q;
  logic signed [8:0] s1_x_q;
  logic [CH_W-1:0]  s1_ch_q;
  logic [31:0]      s1_m_q;
  logic [4:0]       s1_n_q;

  // Stage 2: full-precision product
  logic             s2_valid_q;
  logic signed [41:0] s2_p_q;
  logic [CH_W-1:0]  s2_ch_q;
  logic [4:0]       s2_n_q;

  // Stage 3: saturated output
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [CH_W-1:0]  out_ch_q;

  // Combinational datapath
  logic             advance_s;
  logic             accept_s;
  logic signed [8:0]  x_d;
  logic signed [41:0] x_ext_s;
  logic signed [41:0] m_ext_s;
  logic signed [41:0] p_d;
  logic signed [42:0] p_ext_s;
  logic signed [42:0] rnd_s;
  logic signed [42:0] sum_s;
  logic signed [42:0] shr_s;
  logic [31:0]        sat_d;

  // The whole pipe moves only when the output register is free or draining.
  assign advance_s   = !out_valid_q || out_ready_i;
  assign accept_s    = in_valid_i && advance_s;
  assign in_ready_o  = advance_s;

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

  // Next channel index with wrap at NUM_CH-1
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    if (ch_cnt_q == CH_W'(NUM_CH - 1)) begin
      ch_cnt_d = {CH_W{1'b0}};
    end else begin
      ch_cnt_d = ch_cnt_q + {{(CH_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage-1 and stage-2 arithmetic: zero-point removal and widening multiply
  always_comb begin
    // 9-bit difference covers -255..255 without overflow
    x_d     = {in_data_i[7], in_data_i} - {zp_i[7], zp_i};
    x_ext_s = {{33{s1_x_q[8]}}, s1_x_q};
    // M is unsigned: zero-extend so it enters the signed multiply as positive
    m_ext_s = {10'b0, s1_m_q};
    p_d     = x_ext_s * m_ext_s;
  end

  // Stage-3 arithmetic: optional rounding, arithmetic shift, int32 saturation
  always_comb begin
    p_ext_s = {s2_p_q[41], s2_p_q};
`ifdef DEQUANT_ROUND_EN
    if (s2_n_q != 5'd0) begin
      rnd_s = 43'sd1 <<< (s2_n_q - 5'd1);
    end else begin
      rnd_s = 43'sd0;
    end
`else
    rnd_s = 43'sd0;
`endif
    sum_s = p_ext_s + rnd_s;
    shr_s = sum_s >>> s2_n_q;
    // Fits in int32 when bits 42..31 are all copies of the sign bit
    if (shr_s[42:31] == {12{shr_s[42]}}) begin
      sat_d = shr_s[31:0];
    end else if (shr_s[42]) begin
      sat_d = 32'h8000_0000;
    end else begin
      sat_d = 32'h7FFF_FFFF;
    end
  end

  // Scale-table write port; independent of stall state
  always_ff @(posedge clk) begin
    if (cfg_we_i) begin
      m_tab_q[cfg_addr_i] <= cfg_m_i;
      n_tab_q[cfg_addr_i] <= cfg_n_i;
    end
  end

  // Channel counter: clear wins, but the beat accepted alongside a clear
  // has already sampled the pre-clear value into stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q <= {CH_W{1'b0}};
    end else if (ch_clear_i) begin
      ch_cnt_q <= {CH_W{1'b0}};
    end else if (accept_s) begin
      ch_cnt_q <= ch_cnt_d;
    end
  end

  // Pipeline registers, all gated by the common advance enable
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= 9'sd0;
      s1_ch_q     <= {CH_W{1'b0}};
      s1_m_q      <= 32'd0;
      s1_n_q      <= 5'd0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= 42'sd0;
      s2_ch_q     <= {CH_W{1'b0}};
      s2_n_q      <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_ch_q    <= {CH_W{1'b0}};
    end else if (advance_s) begin
      s1_valid_q  <= in_valid_i;
      s1_x_q      <= x_d;
      s1_ch_q     <= ch_cnt_q;
      // Registered read: a same-cycle table write is seen only by later beats
      s1_m_q      <= m_tab_q[ch_cnt_q];
      s1_n_q      <= n_tab_q[ch_cnt_q];
      s2_valid_q  <= s1_valid_q;
      s2_p_q      <= p_d;
      s2_ch_q     <= s1_ch_q;
      s2_n_q      <= s1_n_q;
      out_valid_q <= s2_valid_q;
      // Output payload only moves with a real beat, keeping it quiet on bubbles
      if (s2_valid_q) begin
        out_data_q <= sat_d;
        out_ch_q   <= s2_ch_q;
      end
    end
  end

endmodule

// File: tb/tb_dequantizer.sv
// ---------------------------------------------------------------------------
// tb_dequantizer
//
// Directed, self-checking bench for dequantizer. A table of single-beat
// vectors with hand-computed results is applied first; hand-written
// sequences then cover channel wrap / clear, output backpressure,
// same-cycle table write vs lookup, and reset in the middle of a stream.
// Ends with one TB_RESULT summary line.
// ---------------------------------------------------------------------------
module tb_dequantizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data_i = 8'd0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  zp_i = 8'd0;
  logic        ch_clear_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_addr_i = 4'd0;
  logic [31:0] cfg_m_i = 32'd0;
  logic [4:0]  cfg_n_i = 5'd0;
  logic [31:0] out_data_o;
  logic [3:0]  out_ch_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;

  dequantizer #(.NUM_CH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .zp_i        (zp_i),
    .ch_clear_i  (ch_clear_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_m_i     (cfg_m_i),
    .cfg_n_i     (cfg_n_i),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  zp;
    logic [31:0] m;
    logic [4:0]  n;
    logic [31:0] exp_floor;
    logic [31:0] exp_round;
  } vec_t;

  vec_t vec [12];

  // Output monitor: records every beat that transfers at the next rising edge
  logic [31:0] mon_data_q [$];
  logic [3:0]  mon_ch_q   [$];
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid_o && out_ready_i) begin
      mon_data_q.push_back(out_data_o);
      mon_ch_q.push_back(out_ch_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [31:0] m, input logic [4:0] n);
    cfg_we_i   = 1'b1;
    cfg_addr_i = a;
    cfg_m_i    = m;
    cfg_n_i    = n;
    tick();
    cfg_we_i   = 1'b0;
  endtask

  task automatic clear_ch();
    ch_clear_i = 1'b1;
    tick();
    ch_clear_i = 1'b0;
  endtask

  // Send one beat into an idle pipe and check the single result it produces
  task automatic send_and_check(input string tag, input logic [7:0] din,
                                input logic [31:0] exp_d, input logic [3:0] exp_ch,
                                output int lat);
    bit got;
    in_data_i  = din;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (out_valid_o) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_data"},  out_data_o, exp_d);
    check({tag, "_ch"},    32'(out_ch_o), 32'(exp_ch));
    tick();
  endtask

  initial begin
    int lat;
    int idx;
    bit acc;
    logic [31:0] exp_d;
    logic [3:0]  exp_c;
    logic [31:0] c_data [7];
    logic [3:0]  c_ch   [7];

    //            din     zp      M             n      floor          round
    vec[0]  = '{8'd10,  8'd0,   32'd3,         5'd1,  32'd15,        32'd15};
    vec[1]  = '{8'd5,   8'd0,   32'd1,         5'd1,  32'd2,         32'd3};
    vec[2]  = '{8'hFB,  8'd0,   32'd1,         5'd1,  32'hFFFF_FFFD, 32'hFFFF_FFFE};
    vec[3]  = '{8'h80,  8'd127, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 32'h8000_0000};
    vec[4]  = '{8'd127, 8'h80,  32'hFFFF_FFFF, 5'd0,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vec[5]  = '{8'hF9,  8'd3,   32'd100,       5'd2,  32'hFFFF_FF06, 32'hFFFF_FF06};
    vec[6]  = '{8'd100, 8'hE4,  32'h0001_0000, 5'd4,  32'h0008_0000, 32'h0008_0000};
    vec[7]  = '{8'd1,   8'd0,   32'h8000_0000, 5'd0,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vec[8]  = '{8'hFF,  8'd0,   32'h8000_0000, 5'd0,  32'h8000_0000, 32'h8000_0000};
    vec[9]  = '{8'd3,   8'd0,   32'd1,         5'd31, 32'd0,         32'd0};
    vec[10] = '{8'hFD,  8'd0,   32'd1,         5'd31, 32'hFFFF_FFFF, 32'd0};
    vec[11] = '{8'd7,   8'd0,   32'd5,         5'd3,  32'd4,         32'd4};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data",  out_data_o, 32'd0);
    check("rst_out_ch",    32'(out_ch_o), 32'd0);
    check("rst_in_ready",  32'(in_ready_o), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Single-beat vectors on channel 0
    for (int i = 0; i < 12; i++) begin
      zp_i       = vec[i].zp;
      ch_clear_i = 1'b1;
      write_cfg(4'd0, vec[i].m, vec[i].n);
      ch_clear_i = 1'b0;
`ifdef DEQUANT_ROUND_EN
      exp_d = vec[i].exp_round;
`else
      exp_d = vec[i].exp_floor;
`endif
      send_and_check($sformatf("vec%0d", i), vec[i].din, exp_d, 4'd0, lat);
      if (i == 0) check("latency", 32'(lat), 32'd3);
    end

    // Channel cycling with wrap, and a clear on the same cycle as beat 7
    for (int c = 0; c < 16; c++) write_cfg(4'(c), 32'(c + 1), 5'd0);
    zp_i = 8'd0;
    clear_ch();
    mon_data_q.delete();
    mon_ch_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data_i  = 8'd1;
      in_valid_i = 1'b1;
      ch_clear_i = (i == 7);
      tick();
    end
    in_valid_i = 1'b0;
    ch_clear_i = 1'b0;
    repeat (6) tick();
    check("wrap_count", 32'(mon_data_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < mon_data_q.size(); i++) begin
      exp_c = (i <= 7) ? 4'(i) : 4'(i - 8);
      check($sformatf("wrap%0d_ch", i),   32'(mon_ch_q[i]), 32'(exp_c));
      check($sformatf("wrap%0d_data", i), mon_data_q[i], 32'(exp_c) + 32'd1);
    end

    // Backpressure: output stalls once three beats are in flight
    clear_ch();
    mon_data_q.delete();
    mon_ch_q.delete();
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      out_ready_i = (cyc >= 8);
      in_valid_i  = 1'b1;
      in_data_i   = 8'(10 + idx);
      @(negedge clk);
      acc = in_ready_o;
      if (cyc >= 3 && cyc <= 7) begin
        check($sformatf("stall%0d_valid", cyc), 32'(out_valid_o), 32'd1);
        check($sformatf("stall%0d_ready", cyc), 32'(in_ready_o), 32'd0);
        check($sformatf("stall%0d_data", cyc),  out_data_o, 32'd10);
      end
      tick();
      if (acc) idx++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) tick();
    check("bp_count", 32'(mon_data_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < mon_data_q.size(); i++) begin
      check($sformatf("bp%0d_ch", i),   32'(mon_ch_q[i]), 32'(i));
      check($sformatf("bp%0d_data", i), mon_data_q[i], 32'((10 + i) * (i + 1)));
    end

    // Table write colliding with a lookup of the same entry
    c_ch   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
    c_data = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd100};
    clear_ch();
    mon_data_q.delete();
    mon_ch_q.delete();
    for (int i = 0; i < 7; i++) begin
      in_data_i  = 8'd1;
      in_valid_i = 1'b1;
      cfg_we_i   = (i == 2);
      cfg_addr_i = 4'd2;
      cfg_m_i    = 32'd100;
      cfg_n_i    = 5'd0;
      ch_clear_i = (i == 3);
      tick();
    end
    in_valid_i = 1'b0;
    cfg_we_i   = 1'b0;
    ch_clear_i = 1'b0;
    repeat (6) tick();
    check("coll_count", 32'(mon_data_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < mon_data_q.size(); i++) begin
      check($sformatf("coll%0d_ch", i),   32'(mon_ch_q[i]), 32'(c_ch[i]));
      check($sformatf("coll%0d_data", i), mon_data_q[i], c_data[i]);
    end
    mon_en = 1'b0;

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      in_data_i  = 8'd1;
      in_valid_i = 1'b1;
      tick();
    end
    in_valid_i = 1'b0;
    check("prerst_valid", 32'(out_valid_o), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(out_valid_o), 32'd0);
    check("midrst_data",  out_data_o, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("drop%0d_valid", k), 32'(out_valid_o), 32'd0);
      tick();
    end
    send_and_check("postrst", 8'd5, 32'd5, 4'd0, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
